// File: rtl/trace_trigger_sequencer.sv
// trace_trigger_sequencer
//   Multi-stage trigger sequencer in the TRACECLK domain. Walks through up to
//   four stages, each scoring hits from its own set of match-rule strobes, and
//   emits a one-cycle trigger when the final stage completes. Configuration is
//   captured on I_arm so that register writes during a run have no effect.
//
// Ports
//   TRACECLK                 sole clock
//   reset                    synchronous active-high reset
//   I_match_bits             per-cycle rule match strobes
//   I_arm / I_abort          start a run at stage 0 / return to IDLE
//   I_rearm                  restart automatically after a fire (latched on arm)
//   I_last_stage             index of the final stage
//   I_stage_rules0..3        rule mask scoring a hit in each stage
//   I_stage_count0..3        hits needed to leave each stage (0 acts as 1)
//   I_timeout                max cycles in any stage > 0 (0 = no timeout)
//   O_trig_out               one-cycle trigger pulse
//   O_armed                  high while in RUN
//   O_state                  IDLE=0, RUN=1, FIRE=2, DONE=3
//   O_stage                  current stage index
//   O_fire_count             completed sequences (wraps)
//   O_timeout_count          stage timeouts (saturates)
module trace_trigger_sequencer #(
   parameter int unsigned pMATCH_RULES   = 8,
   parameter int unsigned pNUM_STAGES    = 4,
   parameter int unsigned pTIMEOUT_WIDTH = 16
) (
   input  logic                      TRACECLK,
   input  logic                      reset,
   input  logic [pMATCH_RULES-1:0]   I_match_bits,
   input  logic                      I_arm,
   input  logic                      I_abort,
   input  logic                      I_rearm,
   input  logic [1:0]                I_last_stage,
   input  logic [pMATCH_RULES-1:0]   I_stage_rules0,
   input  logic [pMATCH_RULES-1:0]   I_stage_rules1,
   input  logic [pMATCH_RULES-1:0]   I_stage_rules2,
   input  logic [pMATCH_RULES-1:0]   I_stage_rules3,
   input  logic [7:0]                I_stage_count0,
   input  logic [7:0]                I_stage_count1,
   input  logic [7:0]                I_stage_count2,
   input  logic [7:0]                I_stage_count3,
   input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
   output logic                      O_trig_out,
   output logic                      O_armed,
   output logic [1:0]                O_state,
   output logic [1:0]                O_stage,
   output logic [7:0]                O_fire_count,
   output logic [7:0]                O_timeout_count
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFire = 2'd2,
      StDone = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [1:0]                stage_q, stage_d;
   logic [7:0]                hitcnt_q, hitcnt_d;
   logic [pTIMEOUT_WIDTH-1:0] timer_q, timer_d;
   logic [7:0]                fire_count_q, fire_count_d;
   logic [7:0]                timeout_count_q, timeout_count_d;
   logic                      trig_q, trig_d;

   // Configuration snapshot taken on arm
   logic [1:0]                last_stage_q;
   logic [pMATCH_RULES-1:0]   rules_q [pNUM_STAGES];
   logic [7:0]                count_q [pNUM_STAGES];
   logic [pTIMEOUT_WIDTH-1:0] timeout_q;
   logic                      rearm_q;

   logic       hit;
   logic [7:0] need;
   logic       complete;
   logic       timer_active;
   logic       timed_out;

   assign hit          = |(I_match_bits & rules_q[stage_q]);
   assign need         = (count_q[stage_q] == 8'd0) ? 8'd1 : count_q[stage_q];
   assign complete     = hit && (({1'b0, hitcnt_q} + 9'd1) == {1'b0, need});
   assign timer_active = (stage_q != 2'd0) && (timeout_q != '0);
   // A completing hit on the last window cycle takes precedence over the timeout
   assign timed_out    = timer_active && (timer_q == timeout_q - pTIMEOUT_WIDTH'(1)) && !complete;

   always_comb begin
      state_d         = state_q;
      stage_d         = stage_q;
      hitcnt_d        = hitcnt_q;
      timer_d         = timer_q;
      fire_count_d    = fire_count_q;
      timeout_count_d = timeout_count_q;
      trig_d          = 1'b0;

      if (I_abort) begin
         state_d  = StIdle;
         stage_d  = 2'd0;
         hitcnt_d = 8'd0;
         timer_d  = '0;
      end else if (I_arm) begin
         state_d  = StRun;
         stage_d  = 2'd0;
         hitcnt_d = 8'd0;
         timer_d  = '0;
      end else begin
         case (state_q)
            StRun: begin
               if (complete) begin
                  hitcnt_d = 8'd0;
                  timer_d  = '0;
                  if (stage_q == last_stage_q) begin
                     state_d      = StFire;
                     trig_d       = 1'b1;
                     fire_count_d = fire_count_q + 8'd1;
                  end else begin
                     stage_d = stage_q + 2'd1;
                  end
               end else if (timed_out) begin
                  stage_d  = 2'd0;
                  hitcnt_d = 8'd0;
                  timer_d  = '0;
                  if (timeout_count_q != 8'hff) begin
                     timeout_count_d = timeout_count_q + 8'd1;
                  end
               end else begin
                  if (hit) begin
                     hitcnt_d = hitcnt_q + 8'd1;
                  end
                  if (timer_active) begin
                     timer_d = timer_q + pTIMEOUT_WIDTH'(1);
                  end
               end
            end
            StFire: begin
               if (rearm_q) begin
                  state_d  = StRun;
                  stage_d  = 2'd0;
                  hitcnt_d = 8'd0;
                  timer_d  = '0;
               end else begin
                  state_d = StDone;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge TRACECLK) begin
      if (reset) begin
         state_q         <= StIdle;
         stage_q         <= 2'd0;
         hitcnt_q        <= 8'd0;
         timer_q         <= '0;
         fire_count_q    <= 8'd0;
         timeout_count_q <= 8'd0;
         trig_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         stage_q         <= stage_d;
         hitcnt_q        <= hitcnt_d;
         timer_q         <= timer_d;
         fire_count_q    <= fire_count_d;
         timeout_count_q <= timeout_count_d;
         trig_q          <= trig_d;
      end
   end

   always_ff @(posedge TRACECLK) begin
      if (reset) begin
         last_stage_q <= 2'd0;
         timeout_q    <= '0;
         rearm_q      <= 1'b0;
         for (int i = 0; i < int'(pNUM_STAGES); i++) begin
            rules_q[i] <= '0;
            count_q[i] <= 8'd0;
         end
      end else if (I_arm && !I_abort) begin
         last_stage_q <= I_last_stage;
         timeout_q    <= I_timeout;
         rearm_q      <= I_rearm;
         rules_q[0]   <= I_stage_rules0;
         rules_q[1]   <= I_stage_rules1;
         rules_q[2]   <= I_stage_rules2;
         rules_q[3]   <= I_stage_rules3;
         count_q[0]   <= I_stage_count0;
         count_q[1]   <= I_stage_count1;
         count_q[2]   <= I_stage_count2;
         count_q[3]   <= I_stage_count3;
      end
   end

   assign O_trig_out      = trig_q;
   assign O_armed         = (state_q == StRun);
   assign O_state         = state_q;
   assign O_stage         = stage_q;
   assign O_fire_count    = fire_count_q;
   assign O_timeout_count = timeout_count_q;

endmodule

// File: tb/tb_trace_trigger_sequencer.sv
// tb_trace_trigger_sequencer
//   Directed bench for trace_trigger_sequencer. Inputs change 1 time unit after
//   the rising edge; outputs are checked at that same point, reflecting the edge.
module tb_trace_trigger_sequencer;

   logic        clk;
   logic        reset;
   logic [7:0]  match_bits;
   logic        arm, abort_in, rearm;
   logic [1:0]  last_stage;
   logic [7:0]  rules0, rules1, rules2, rules3;
   logic [7:0]  count0, count1, count2, count3;
   logic [15:0] timeout;
   logic        trig_out, armed;
   logic [1:0]  state, stage;
   logic [7:0]  fire_count, timeout_count;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses;

   trace_trigger_sequencer dut (
      .TRACECLK        (clk),
      .reset           (reset),
      .I_match_bits    (match_bits),
      .I_arm           (arm),
      .I_abort         (abort_in),
      .I_rearm         (rearm),
      .I_last_stage    (last_stage),
      .I_stage_rules0  (rules0),
      .I_stage_rules1  (rules1),
      .I_stage_rules2  (rules2),
      .I_stage_rules3  (rules3),
      .I_stage_count0  (count0),
      .I_stage_count1  (count1),
      .I_stage_count2  (count2),
      .I_stage_count3  (count3),
      .I_timeout       (timeout),
      .O_trig_out      (trig_out),
      .O_armed         (armed),
      .O_state         (state),
      .O_stage         (stage),
      .O_fire_count    (fire_count),
      .O_timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic set_cfg(input logic [1:0] ls, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [15:0] to, input logic ra);
      last_stage = ls;
      rules0 = r0; rules1 = r1; rules2 = r2; rules3 = 8'h00;
      count0 = c0; count1 = c1; count2 = c2; count3 = 8'd0;
      timeout = to;
      rearm = ra;
   endtask

   initial begin
      reset = 1'b1; match_bits = 8'h00; arm = 1'b0; abort_in = 1'b0;
      set_cfg(2'd0, 8'h00, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      tick(); tick();
      check_eq("rst_state", state, 0);
      check_eq("rst_stage", stage, 0);
      check_eq("rst_trig", trig_out, 0);
      check_eq("rst_armed", armed, 0);
      check_eq("rst_fire", fire_count, 0);
      check_eq("rst_tocnt", timeout_count, 0);
      reset = 1'b0;
      tick();

      // Single stage, 3 non-consecutive hits; strobes on the arm cycle are ignored
      set_cfg(2'd0, 8'h01, 8'h00, 8'h00, 8'd3, 8'd0, 8'd0, 16'd0, 1'b0);
      match_bits = 8'h01;
      do_arm();
      check_eq("a_armed", armed, 1);
      check_eq("a_state_run", state, 1);
      tick();                       // hit 1
      match_bits = 8'h00; tick();
      match_bits = 8'h01; tick();   // hit 2
      check_eq("a_no_trig_early", trig_out, 0);
      match_bits = 8'h00; tick();
      match_bits = 8'h01; tick();   // hit 3 -> FIRE
      check_eq("a_trig", trig_out, 1);
      check_eq("a_state_fire", state, 2);
      check_eq("a_fire_cnt", fire_count, 1);
      match_bits = 8'h00; tick();
      check_eq("a_trig_low", trig_out, 0);
      check_eq("a_state_done", state, 3);
      tick();
      check_eq("a_done_hold", state, 3);

      // Three stages; count2=0 behaves as 1
      set_cfg(2'd2, 8'h01, 8'h02, 8'h04, 8'd1, 8'd1, 8'd0, 16'd0, 1'b0);
      do_arm();
      match_bits = 8'h01; tick();
      check_eq("b_stage1", stage, 1);
      match_bits = 8'h02; tick();
      check_eq("b_stage2", stage, 2);
      check_eq("b_no_trig", trig_out, 0);
      match_bits = 8'h04; tick();
      check_eq("b_trig", trig_out, 1);
      check_eq("b_fire_cnt", fire_count, 2);
      match_bits = 8'h00; tick();
      check_eq("b_done", state, 3);
      do_arm();
      match_bits = 8'h04; tick();
      check_eq("b_wrong_rule_stage", stage, 0);
      check_eq("b_wrong_rule_state", state, 1);

      // Timeout of 5 cycles in stage 1
      set_cfg(2'd1, 8'h01, 8'h02, 8'h00, 8'd1, 8'd1, 8'd0, 16'd5, 1'b0);
      match_bits = 8'h00;
      do_arm();
      match_bits = 8'h01; tick();   // enter stage 1
      check_eq("c_enter", stage, 1);
      match_bits = 8'h00;
      repeat (4) tick();
      check_eq("c_still_s1", stage, 1);
      check_eq("c_tocnt0", timeout_count, 0);
      tick();
      check_eq("c_to_stage0", stage, 0);
      check_eq("c_tocnt1", timeout_count, 1);
      check_eq("c_to_running", state, 1);
      // Completing hit on the 5th cycle beats the timeout
      match_bits = 8'h01; tick();
      check_eq("c2_enter", stage, 1);
      match_bits = 8'h00;
      repeat (4) tick();
      match_bits = 8'h02; tick();
      check_eq("c2_trig", trig_out, 1);
      check_eq("c2_tocnt", timeout_count, 1);
      check_eq("c2_fire_cnt", fire_count, 3);
      // Non-completing hit on the 5th cycle still times out
      set_cfg(2'd1, 8'h01, 8'h02, 8'h00, 8'd1, 8'd2, 8'd0, 16'd5, 1'b0);
      match_bits = 8'h00;
      do_arm();
      match_bits = 8'h01; tick();
      match_bits = 8'h00;
      repeat (4) tick();
      match_bits = 8'h02; tick();
      check_eq("c3_to_stage0", stage, 0);
      check_eq("c3_tocnt2", timeout_count, 2);

      // Auto re-arm: strobes every cycle give a trigger every other cycle
      set_cfg(2'd0, 8'h01, 8'h00, 8'h00, 8'd1, 8'd0, 8'd0, 16'd0, 1'b1);
      match_bits = 8'h00;
      do_arm();
      pulses = 0;
      match_bits = 8'h01;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (trig_out === 1'b1) pulses++;
      end
      match_bits = 8'h00;
      check_eq("d_pulses", pulses, 5);
      check_eq("d_fire_cnt", fire_count, 8);
      check_eq("d_state_run", state, 1);

      // Abort and arm together: abort wins, counters kept
      abort_in = 1'b1; arm = 1'b1; tick();
      abort_in = 1'b0; arm = 1'b0;
      check_eq("e_state_idle", state, 0);
      check_eq("e_armed", armed, 0);
      check_eq("e_fire_kept", fire_count, 8);
      check_eq("e_tocnt_kept", timeout_count, 2);

      // Config changes without arm are ignored; multi-strobe hit counts once
      set_cfg(2'd0, 8'h03, 8'h00, 8'h00, 8'd2, 8'd0, 8'd0, 16'd0, 1'b0);
      do_arm();
      set_cfg(2'd3, 8'hff, 8'hff, 8'hff, 8'd1, 8'd1, 8'd1, 16'd1, 1'b1);
      match_bits = 8'h0c; tick();
      check_eq("f_masked", state, 1);
      match_bits = 8'h03; tick();
      check_eq("f_once_per_cycle", state, 1);
      match_bits = 8'h01; tick();
      check_eq("f_trig", trig_out, 1);
      check_eq("f_fire_cnt", fire_count, 9);
      // Arm during FIRE: arm wins, no double count
      match_bits = 8'h00;
      do_arm();
      check_eq("f_arm_in_fire", state, 1);
      check_eq("f_trig_low", trig_out, 0);
      check_eq("f_fire_cnt2", fire_count, 9);

      // Reset mid-run at stage 2
      set_cfg(2'd2, 8'h01, 8'h02, 8'h04, 8'd1, 8'd1, 8'd1, 16'd0, 1'b0);
      do_arm();
      match_bits = 8'h01; tick();
      match_bits = 8'h02; tick();
      match_bits = 8'h00;
      check_eq("g_stage2", stage, 2);
      reset = 1'b1; tick();
      reset = 1'b0;
      check_eq("g_state", state, 0);
      check_eq("g_stage", stage, 0);
      check_eq("g_trig", trig_out, 0);
      check_eq("g_fire", fire_count, 0);
      check_eq("g_tocnt", timeout_count, 0);
      tick();
      check_eq("g_idle_hold", state, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
